// File: rtl/click_conditioner_pkg.sv
// Shared FSM encodings and held-count helpers for click_conditioner.
package click_conditioner_pkg;

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] DEB_PRESS   = 2'd1;
    localparam logic [1:0] HELD        = 2'd2;
    localparam logic [1:0] DEB_RELEASE = 2'd3;

    localparam int unsigned HELD_W = 4;
    localparam logic [HELD_W-1:0] HELD_MAX = '1;

    function automatic logic [HELD_W-1:0] held_sat_inc(input logic [HELD_W-1:0] v);
        return (v == HELD_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/click_conditioner_sync_2ff.sv
// Two-flop synchronizer with asynchronous reset to a configurable value.
module sync_2ff #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/click_conditioner.sv
// Debounces a raw push-button into a one-cycle click pulse plus debounced level.
// Optional auto-repeat while held is compiled in with CLICK_AUTOREPEAT_EN.
module click_conditioner
    import click_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned REPEAT_DELAY    = 32,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_raw,
    input  logic              enable,
    output logic              click,
    output logic              pressed,
    output logic [HELD_W-1:0] held_n
);

    if (DEBOUNCE_CYCLES < 1 || (1 << CNT_W) <= DEBOUNCE_CYCLES ||
        (1 << CNT_W) <= REPEAT_DELAY || REPEAT_PERIOD < 1 ||
        REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
        $error("click_conditioner: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic btn_s;
    logic rst_hold;

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b0)) u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_s)
    );

    // Held high for two edges after rst falls, so state leaves reset synchronously.
    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_rst_sync (
        .clk (clk),
        .rst (rst),
        .d   (1'b0),
        .q   (rst_hold)
    );

    logic [1:0]        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              click_n, pressed_n;
    logic [HELD_W-1:0] held_n_n;
    logic              do_accept, do_release;

`ifdef CLICK_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic             armed, armed_n;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed   <= 1'b0;
            rep_cnt <= '0;
        end else begin
            armed   <= armed_n;
            rep_cnt <= rep_cnt_n;
        end
    end
`endif

    // With DEBOUNCE_CYCLES==1 the first differing sample is already the last one.
    always_comb begin
        do_accept  = 1'b0;
        do_release = 1'b0;
        case (state)
            IDLE:        do_accept  = btn_s && (DEBOUNCE_CYCLES == 1);
            DEB_PRESS:   do_accept  = btn_s && (cnt == DEB_LAST);
            HELD:        do_release = !btn_s && (DEBOUNCE_CYCLES == 1);
            DEB_RELEASE: do_release = !btn_s && (cnt == DEB_LAST);
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        click_n   = 1'b0;
        pressed_n = pressed;
        held_n_n  = held_n;
`ifdef CLICK_AUTOREPEAT_EN
        armed_n   = armed;
        rep_cnt_n = rep_cnt;
`endif

        case (state)
            IDLE: if (btn_s) begin
                state_n = DEB_PRESS;
                cnt_n   = CNT_W'(1);
            end
            DEB_PRESS: if (!btn_s) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            HELD: if (!btn_s) begin
                state_n = DEB_RELEASE;
                cnt_n   = CNT_W'(1);
            end
            DEB_RELEASE: if (btn_s) begin
                state_n = HELD;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        endcase

`ifdef CLICK_AUTOREPEAT_EN
        // Repeat counter only advances on stable HELD cycles; DEB_RELEASE leaves it frozen.
        if (state == HELD && btn_s && armed) begin
            if (rep_cnt == REP_LAST) begin
                rep_cnt_n = REP_RELOAD;
                click_n   = enable;
                if (enable)
                    held_n_n = held_sat_inc(held_n);
            end else begin
                rep_cnt_n = rep_cnt + 1'b1;
            end
        end
`endif

        if (do_accept) begin
            state_n   = HELD;
            cnt_n     = '0;
            pressed_n = 1'b1;
            click_n   = enable;
            held_n_n  = HELD_W'(enable);
`ifdef CLICK_AUTOREPEAT_EN
            armed_n   = enable;
            rep_cnt_n = '0;
`endif
        end

        if (do_release) begin
            state_n   = IDLE;
            cnt_n     = '0;
            pressed_n = 1'b0;
            held_n_n  = '0;
`ifdef CLICK_AUTOREPEAT_EN
            armed_n   = 1'b0;
            rep_cnt_n = '0;
`endif
        end

        if (rst_hold) begin
            state_n   = IDLE;
            cnt_n     = '0;
            click_n   = 1'b0;
            pressed_n = 1'b0;
            held_n_n  = '0;
`ifdef CLICK_AUTOREPEAT_EN
            armed_n   = 1'b0;
            rep_cnt_n = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            click   <= 1'b0;
            pressed <= 1'b0;
            held_n  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            click   <= click_n;
            pressed <= pressed_n;
            held_n  <= held_n_n;
        end
    end

endmodule

// File: tb/tb_click_conditioner.sv
// Self-checking bench for click_conditioner: run-length reference model plus directed scenarios.
module tb_click_conditioner;

    localparam int DEB = 4;
    localparam int DLY = 32;
    localparam int PER = 8;
`ifdef CLICK_AUTOREPEAT_EN
    localparam bit AUTOREP   = 1'b1;
    localparam int EXP_HOLD60 = 5;
    localparam int EXP_SAT    = 15;
`else
    localparam bit AUTOREP   = 1'b0;
    localparam int EXP_HOLD60 = 1;
    localparam int EXP_SAT    = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic       enable;
    logic       click;
    logic       pressed;
    logic [3:0] held_n;

    always #5 clk = ~clk;

    click_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (8),
        .REPEAT_DELAY    (DLY),
        .REPEAT_PERIOD   (PER)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .enable  (enable),
        .click   (click),
        .pressed (pressed),
        .held_n  (held_n)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the debounced level flips after DEB consecutive differing samples.
    bit m_s1, m_s2;
    bit m_level, m_click, m_armed;
    int m_run, m_held, m_age, m_hold;

    logic rst_req;
    int   tick_no = 0;
    int   n_clicks = 0;
    int   last_click = -1;
    int   fall_tick = -1;
    int   peak_held = 0;
    logic prev_click = 1'b0;
    logic prev_pressed = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level = 1'b0; m_click = 1'b0; m_armed = 1'b0;
        m_run = 0; m_held = 0; m_age = 0;
    endtask

    task automatic model_edge();
        bit bs;
        if (rst) begin
            model_reset();
            m_s1 = 1'b0; m_s2 = 1'b0; m_hold = 2;
            return;
        end
        bs   = m_s2;
        m_s2 = m_s1;
        m_s1 = btn_raw;
        if (m_hold > 0) begin
            m_hold--;
            model_reset();
            return;
        end
        m_click = 1'b0;
        if (bs != m_level) begin
            m_run++;
            if (m_run == DEB) begin
                m_level = bs;
                m_run   = 0;
                if (bs) begin
                    m_click = enable; m_held = enable ? 1 : 0;
                    m_armed = enable; m_age = 0;
                end else begin
                    m_held = 0; m_armed = 1'b0;
                end
            end
        end else begin
            if (AUTOREP && m_level && m_armed && m_run == 0) begin
                m_age++;
                if (m_age >= DLY && (m_age - DLY) % PER == 0) begin
                    m_click = enable;
                    if (enable && m_held < 15) m_held++;
                end
            end
            m_run = 0;
        end
    endtask

    task automatic tick(input logic b, input logic e);
        @(negedge clk);
        btn_raw = b; enable = e; rst = rst_req;
        @(posedge clk);
        model_edge();
        tick_no++;
        #1;
        check("click", click, m_click);
        check("pressed", pressed, m_level);
        check("held_n", held_n, m_held);
        if (click) begin
            check("click_not_adjacent", prev_click, 1'b0);
            n_clicks++;
            last_click = tick_no;
        end
        if (prev_pressed && !pressed) fall_tick = tick_no;
        if (int'(held_n) > peak_held) peak_held = held_n;
        prev_click   = click;
        prev_pressed = pressed;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_hold = 2;
        check("async_rst_click", click, 1'b0);
        check("async_rst_pressed", pressed, 1'b0);
        check("async_rst_held_n", held_n, 4'd0);
        prev_click = 1'b0; prev_pressed = 1'b0;
        rst_req = 1'b1;
        repeat (2) tick(btn_raw, enable);
        rst_req = 1'b0;
    endtask

    initial begin
        int t0, c0, lvl, len;
        logic en;
        rst = 1'b1; rst_req = 1'b1; btn_raw = 1'b0; enable = 1'b1;
        model_reset(); m_s1 = 1'b0; m_s2 = 1'b0; m_hold = 2;
        repeat (3) tick(1'b0, 1'b1);
        check("reset_click", click, 1'b0);
        check("reset_pressed", pressed, 1'b0);
        rst_req = 1'b0;
        repeat (5) tick(1'b0, 1'b1);

        // Clean press and release.
        c0 = n_clicks; t0 = tick_no + 1;
        repeat (20) tick(1'b1, 1'b1);
        check("clean_clicks", n_clicks - c0, 1);
        check("clean_latency", last_click - t0, DEB + 1);
        check("clean_pressed", pressed, 1'b1);
        check("clean_held_n", held_n, 4'd1);
        t0 = tick_no + 1;
        repeat (20) tick(1'b0, 1'b1);
        check("release_latency", fall_tick - t0, DEB + 1);
        check("release_pressed", pressed, 1'b0);
        check("release_held_n", held_n, 4'd0);

        // Bounce 1,0,1,0 every 2 cycles, then steady.
        c0 = n_clicks;
        repeat (2) begin
            repeat (2) tick(1'b1, 1'b1);
            repeat (2) tick(1'b0, 1'b1);
        end
        check("bounce_no_early_click", n_clicks - c0, 0);
        t0 = tick_no + 1;
        repeat (15) tick(1'b1, 1'b1);
        check("bounce_clicks", n_clicks - c0, 1);
        check("bounce_latency", last_click - t0, DEB + 1);
        repeat (15) tick(1'b0, 1'b1);

        // Short glitch.
        c0 = n_clicks;
        repeat (3) tick(1'b1, 1'b1);
        repeat (15) tick(1'b0, 1'b1);
        check("glitch_no_click", n_clicks - c0, 0);

        // Enable low at acceptance, raised while held.
        c0 = n_clicks;
        repeat (DEB + 2) tick(1'b1, 1'b0);
        repeat (15) tick(1'b1, 1'b1);
        check("gated_no_click", n_clicks - c0, 0);
        check("gated_pressed", pressed, 1'b1);
        check("gated_held_n", held_n, 4'd0);
        repeat (15) tick(1'b0, 1'b1);

        // Reset mid-press with button still held.
        repeat (10) tick(1'b1, 1'b1);
        do_reset();
        c0 = n_clicks; t0 = tick_no + 1;
        repeat (15) tick(1'b1, 1'b1);
        check("rst_reclick_count", n_clicks - c0, 1);
        check("rst_reclick_latency", last_click - t0, DEB + 1);
        repeat (15) tick(1'b0, 1'b1);

        // Rapid presses.
        c0 = n_clicks;
        repeat (7) begin
            repeat (10) tick(1'b1, 1'b1);
            repeat (10) tick(1'b0, 1'b1);
        end
        check("rapid_clicks", n_clicks - c0, 7);

        // 60-cycle hold: auto-repeat when compiled in.
        c0 = n_clicks; peak_held = 0;
        repeat (60) tick(1'b1, 1'b1);
        repeat (20) tick(1'b0, 1'b1);
        check("hold60_clicks", n_clicks - c0, EXP_HOLD60);
        check("hold60_held_n", peak_held, EXP_HOLD60);

        // Long hold: held_n saturation.
        peak_held = 0;
        repeat (200) tick(1'b1, 1'b1);
        repeat (20) tick(1'b0, 1'b1);
        check("sat_held_n", peak_held, EXP_SAT);

        // Randomized runs checked cycle-by-cycle against the model.
        en = 1'b1;
        repeat (60) begin
            lvl = $urandom_range(0, 1);
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 7) == 0) en = ~en;
            repeat (len) tick(lvl[0], en);
            if ($urandom_range(0, 29) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
